// File: rtl/regwr_pkg.sv
// -----------------------------------------------------------------------------
// regwr_pkg
// Shared types and constants for the register-file write arbiter.
//   regwr_entry_t : one buffered AUX write {live, reg_num, data}
//   REG_ZERO      : hard-wired zero register; writes to it are no-ops
//   AGE_W         : width of the head-of-buffer age counter
//   reg_onehot()  : one-hot decode of a 5-bit register number
// -----------------------------------------------------------------------------
package regwr_pkg;

  // 'reg' is a language keyword, so the destination field is reg_num.
  typedef struct packed {
    logic        live;
    logic [4:0]  reg_num;
    logic [31:0] data;
  } regwr_entry_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         AGE_W    = 4;

  function automatic logic [31:0] reg_onehot(input logic [4:0] r);
    logic [31:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regwr_fifo.sv
// -----------------------------------------------------------------------------
// regwr_fifo
// Circular buffer of regwr_entry_t holding AUX writes until the port is free.
// Entries that a younger WB write has superseded are marked dead in place so
// ordering is preserved; the arbiter later pops them without writing.
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   push, push_reg/data : append a live entry at the tail (caller guarantees !full)
//   pop                 : drop the head entry (caller guarantees !empty)
//   kill_en, kill_reg   : mark every live entry targeting kill_reg as dead;
//                         the entry being pushed this cycle is exempt
//   full, empty         : occupancy flags (dead entries still occupy a slot)
//   head                : view of the oldest entry
//   pend_mask           : OR of one-hot(reg_num) over live entries, bit 0 = 0
// -----------------------------------------------------------------------------
module regwr_fifo
  import regwr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [4:0]         push_reg,
  input  logic [31:0]        push_data,
  input  logic               pop,
  input  logic               kill_en,
  input  logic [4:0]         kill_reg,
  output logic               full,
  output logic               empty,
  output regwr_entry_t       head,
  output logic [31:0]        pend_mask
);

  localparam int            PW        = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_CNT = (PW+1)'(DEPTH);

  regwr_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase

      // The pushed slot is always free (not full), so writing it last-wins
      // is what exempts the younger same-cycle AUX result from the kill.
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == PW'(i))) begin
          mem[i] <= '{live: 1'b1, reg_num: push_reg, data: push_data};
        end else if (pop && (rd_ptr == PW'(i))) begin
          mem[i].live <= 1'b0;
        end else if (kill_en && mem[i].live && (mem[i].reg_num == kill_reg)) begin
          mem[i].live <= 1'b0;
        end
      end
    end
  end

  // Popped slots have live cleared, so live alone identifies pending writes.
  always_comb begin
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].live) m = m | reg_onehot(mem[i].reg_num);
    end
    pend_mask = {m[31:1], 1'b0};
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single register-file write port between the pipeline writeback
// stage (WB, priority, never back-pressured) and an auxiliary multi-cycle
// producer (AUX, valid/ready) whose results wait in a small buffer.
//
// Optional feature macro: REGFILE_ARB_STARVE_EN
//   defined   : head age counter plus registered wb_stall bubble request
//   undefined : wb_stall tied 0; AUX drains only in WB-idle cycles
//
// Parameters:
//   DEPTH        : AUX buffer entries, power of two, >= 2
//   STARVE_LIMIT : head wait cycles before wb_stall asserts, 1..15
//
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   wb_valid/wb_reg/wb_data     : WB write request, always accepted
//   aux_valid/aux_reg/aux_data  : AUX request; aux_ready = buffer not full
//   WE/write_reg_number/
//   write_data                  : registered register-file write port
//   pend_mask                   : registers targeted by live buffered entries
//   wb_stall                    : registered request for a WB bubble
// -----------------------------------------------------------------------------
module regfile_write_arbiter
  import regwr_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_reg,
  input  logic [31:0] aux_data,
  output logic        WE,
  output logic [4:0]  write_reg_number,
  output logic [31:0] write_data,
  output logic [31:0] pend_mask,
  output logic        wb_stall
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("regfile_write_arbiter: DEPTH must be a power of two >= 2");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("regfile_write_arbiter: STARVE_LIMIT must be in 1..15");
  end

  regwr_entry_t head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_push;
  logic         fifo_pop;
  logic         wb_req;
  logic         head_live;

  logic         we_d;
  logic [4:0]   reg_d;
  logic [31:0]  data_d;

  // A WB write to $0 is no request at all, leaving the port to AUX.
  assign wb_req    = wb_valid && (wb_reg != REG_ZERO);
  assign aux_ready = !fifo_full;
  // AUX writes to $0 complete the handshake but are simply dropped.
  assign fifo_push = aux_valid && aux_ready && (aux_reg != REG_ZERO);
  assign head_live = !fifo_empty && head.live;
  // Whenever WB leaves the port free the head goes: live heads write,
  // dead heads are discarded in a slot of their own.
  assign fifo_pop  = !wb_req && !fifo_empty;

  regwr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_reg  (aux_reg),
    .push_data (aux_data),
    .pop       (fifo_pop),
    .kill_en   (wb_req),
    .kill_reg  (wb_reg),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head),
    .pend_mask (pend_mask)
  );

  always_comb begin
    we_d   = 1'b0;
    reg_d  = REG_ZERO;
    data_d = '0;
    if (wb_req) begin
      we_d   = 1'b1;
      reg_d  = wb_reg;
      data_d = wb_data;
    end else if (head_live) begin
      we_d   = 1'b1;
      reg_d  = head.reg_num;
      data_d = head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WE               <= 1'b0;
      write_reg_number <= REG_ZERO;
      write_data       <= '0;
    end else begin
      WE               <= we_d;
      write_reg_number <= reg_d;
      write_data       <= data_d;
    end
  end

`ifdef REGFILE_ARB_STARVE_EN
  localparam logic [AGE_W-1:0] AGE_MAX   = '1;
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age_q;
  logic [AGE_W-1:0] age_d;

  // Only a live head blocked by WB ages; a dead head blocked by WB holds
  // its age so the bubble request still lets it drain.
  always_comb begin
    age_d = age_q;
    if (fifo_empty || fifo_pop) begin
      age_d = '0;
    end else if (head_live && wb_req && (age_q != AGE_MAX)) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q    <= '0;
      wb_stall <= 1'b0;
    end else begin
      age_q    <= age_d;
      wb_stall <= (age_d >= AGE_LIMIT);
    end
  end
`else
  assign wb_stall = 1'b0;
`endif

endmodule
